// File: rtl/ray_unit_scheduler_pkg.sv
// Shared types for the ray unit scheduler: fixed-point ray/AABB/hit records,
// scheduler FSM states and Fixed helpers.
`ifndef BVH_AABB_TEST_UNIT_SIZE
`define BVH_AABB_TEST_UNIT_SIZE 2
`endif

package ray_unit_scheduler_pkg;

  typedef logic signed [31:0] Fixed;  // Q16.16

  typedef struct packed {
    Fixed x;
    Fixed y;
    Fixed z;
  } Vec3;

  typedef struct packed {
    Vec3 origin;
    Vec3 inv_dir;
  } Ray;

  typedef struct packed {
    Vec3         lo;
    Vec3         hi;
    logic [15:0] prim_id;
  } BVH_Primitive_AABB;

  typedef struct packed {
    logic        bHit;
    Fixed        T;
    logic [15:0] prim_id;
  } HitData;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_EVAL,
    RS_WAIT,
    RS_RESP
  } RaySchedState;

  function automatic Fixed FixedInf();
    return 32'sh7FFF_FFFF;
  endfunction

  function automatic logic Fixed_Greater(input Fixed a, input Fixed b);
    return a > b;
  endfunction

  function automatic HitData AccInit();
    return '{bHit: 1'b0, T: FixedInf(), prim_id: 16'd0};
  endfunction

endpackage

// File: rtl/ray_unit_scheduler_arb.sv
// Round-robin arbiter: one-hot grant plus index of the first active request
// found searching upward from i_ptr with wrap.
module rr_arbiter_onehot #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_id,
  output logic               o_any
);

  int w_idx;

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_id           = ID_W'(w_idx);
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ray_unit_scheduler.sv
// Shares one hit-test datapath among NUM_REQ requesters, locking it per traversal
// and accumulating the closest hit. Optional counters: RAY_SCHED_PERF_EN.
module ray_unit_scheduler
  import ray_unit_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  Ray   [NUM_REQ-1:0] req_ray,
  input  BVH_Primitive_AABB [NUM_REQ-1:0][`BVH_AABB_TEST_UNIT_SIZE-1:0] req_prims,
  input  logic [NUM_REQ-1:0] req_any,
  input  logic [NUM_REQ-1:0] req_last,
  output Ray                ru_ray,
  output BVH_Primitive_AABB [`BVH_AABB_TEST_UNIT_SIZE-1:0] ru_prims,
  output logic              ru_any,
  input  HitData            ru_hit_data,
  input  logic              ru_any_hit,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output HitData            rsp_hit
`ifdef RAY_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_batches,
  output logic [31:0]       perf_wait
`endif
);

  // States: IDLE arbitrate | EVAL sample datapath | WAIT locked to owner | RESP hold response
  RaySchedState r_state;
  logic [ID_W-1:0] r_rr_ptr, r_owner;
  Ray     r_ru_ray;
  BVH_Primitive_AABB [`BVH_AABB_TEST_UNIT_SIZE-1:0] r_ru_prims;
  logic   r_ru_any, r_ru_last, r_rsp_valid;
  HitData r_acc;

  logic [NUM_REQ-1:0] w_grant, w_ready;
  logic [ID_W-1:0]    w_win_id, w_sel;
  logic               w_win_any, w_take, w_done;
  HitData             w_acc_nxt;

  rr_arbiter_onehot #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_id    (w_win_id),
    .o_any   (w_win_any)
  );

  always_comb begin
    w_ready = '0;
    case (r_state)
      RS_IDLE: w_ready = w_grant;
      RS_WAIT: w_ready[r_owner] = 1'b1;
      default: w_ready = '0;
    endcase
  end

  assign req_ready = resetn ? w_ready : '0;
  assign w_take    = |(req_valid & w_ready);
  assign w_sel     = (r_state == RS_IDLE) ? w_win_id : r_owner;

  // Strict compare: an equal T from a later batch never displaces the earlier hit.
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_ru_any)
      w_acc_nxt.bHit = r_acc.bHit | ru_any_hit;
    else if (ru_hit_data.bHit && Fixed_Greater(r_acc.T, ru_hit_data.T))
      w_acc_nxt = ru_hit_data;
  end

  assign w_done = r_ru_last | (r_ru_any & w_acc_nxt.bHit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= RS_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_ru_ray    <= '0;
      r_ru_prims  <= '0;
      r_ru_any    <= 1'b0;
      r_ru_last   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_acc       <= AccInit();
    end else begin
      if (w_take) begin
        r_ru_ray   <= req_ray[w_sel];
        r_ru_prims <= req_prims[w_sel];
        r_ru_any   <= req_any[w_sel];
        r_ru_last  <= req_last[w_sel];
      end
      case (r_state)
        RS_IDLE: if (w_take) begin
          r_owner <= w_win_id;
          r_acc   <= AccInit();
          r_state <= RS_EVAL;
        end
        RS_EVAL: begin
          r_acc <= w_acc_nxt;
          if (w_done) begin
            r_state     <= RS_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_state <= RS_WAIT;
          end
        end
        RS_WAIT: if (w_take) r_state <= RS_EVAL;
        RS_RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_rr_ptr    <= (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
          r_state     <= RS_IDLE;
        end
        default: r_state <= RS_IDLE;
      endcase
    end
  end

  assign ru_ray    = r_ru_ray;
  assign ru_prims  = r_ru_prims;
  assign ru_any    = r_ru_any;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_owner;
  assign rsp_hit   = r_acc;

`ifdef RAY_SCHED_PERF_EN
  logic [31:0] r_perf_batches, r_perf_wait;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_batches <= '0;
      r_perf_wait    <= '0;
    end else begin
      if (r_state == RS_EVAL && r_perf_batches != '1)
        r_perf_batches <= r_perf_batches + 1'b1;
      if (r_state == RS_WAIT && !req_valid[r_owner] && r_perf_wait != '1)
        r_perf_wait <= r_perf_wait + 1'b1;
    end
  end

  assign perf_batches = r_perf_batches;
  assign perf_wait    = r_perf_wait;
`endif

endmodule

// File: tb/tb_ray_unit_scheduler.sv
// Directed bench for ray_unit_scheduler: table of single-batch traversals plus
// multi-batch, reset, any-hit early exit, round-robin and hold sequences.
`timescale 1ns/1ps
module tb_ray_unit_scheduler;
  import ray_unit_scheduler_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int US      = `BVH_AABB_TEST_UNIT_SIZE;
  localparam Fixed INF   = 32'sh7FFF_FFFF;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [NUM_REQ-1:0] req_valid = '0, req_ready, req_any = '0, req_last = '0;
  Ray   [NUM_REQ-1:0] req_ray = '0;
  BVH_Primitive_AABB [NUM_REQ-1:0][US-1:0] req_prims = '0;
  Ray   ru_ray;
  BVH_Primitive_AABB [US-1:0] ru_prims;
  logic ru_any, ru_any_hit, rsp_valid, rsp_ready = 1'b0;
  HitData ru_hit_data, rsp_hit;
  logic [ID_W-1:0] rsp_id;
`ifdef RAY_SCHED_PERF_EN
  logic [31:0] perf_batches, perf_wait;
`endif

  ray_unit_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_ray(req_ray),
    .req_prims(req_prims), .req_any(req_any), .req_last(req_last),
    .ru_ray(ru_ray), .ru_prims(ru_prims), .ru_any(ru_any),
    .ru_hit_data(ru_hit_data), .ru_any_hit(ru_any_hit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_hit(rsp_hit)
`ifdef RAY_SCHED_PERF_EN
    , .perf_batches(perf_batches), .perf_wait(perf_wait)
`endif
  );

  always #5 clk = ~clk;

  // Mock datapath: prim 0 carries its own result (id[15]=closest hit, id[14]=any hit, lo.x=T)
  always_comb begin
    ru_hit_data.bHit    = ru_prims[0].prim_id[15];
    ru_hit_data.T       = ru_prims[0].lo.x;
    ru_hit_data.prim_id = ru_prims[0].prim_id;
    ru_any_hit          = ru_prims[0].prim_id[14];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int mon_bad = 0;
  always @(negedge clk) if (mon_en && req_ready[0]) mon_bad++;

  typedef struct {
    int   id;
    bit   any;
    bit   hit;
    bit   ahit;
    Fixed t;
    bit   exp_hit;
    Fixed exp_t;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_batch(input int id, input bit any, input bit last, input bit hit,
                           input bit ahit, input Fixed t, input logic [13:0] tag);
    req_any[id]  = any;
    req_last[id] = last;
    req_ray[id]  = {6{t}};
    for (int u = 0; u < US; u++) req_prims[id][u] = '0;
    req_prims[id][0].lo.x    = t;
    req_prims[id][0].prim_id = {hit, ahit, tag};
  endtask

  // Entered and left at posedge+1ns; hs is the cycle count just after the handshake edge.
  task automatic send(input int id, input bit keep, output int hs);
    bit ok;
    ok = 1'b0;
    hs = 0;
    req_valid[id] = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      #1;
      if (req_ready[id]) begin
        ok = 1'b1;
        @(posedge clk); #1;
        hs = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!keep) req_valid[id] = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(output int rc);
    bit ok;
    ok = 1'b0;
    rc = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        rc = cyc;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) check("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs, hs2, rc, pb0, pw0;
    logic [3:0] exp_ready;
    HitData exp_h;

    vecs[0] = '{0, 1'b0, 1'b1, 1'b0, 32'sd327680,  1'b1, 32'sd327680};
    vecs[1] = '{1, 1'b0, 1'b0, 1'b0, 32'sd131072,  1'b0, INF};
    vecs[2] = '{2, 1'b1, 1'b0, 1'b1, 32'sd65536,   1'b1, INF};
    vecs[3] = '{3, 1'b1, 1'b1, 1'b0, 32'sd65536,   1'b0, INF};
    vecs[4] = '{1, 1'b0, 1'b1, 1'b0, INF,          1'b0, INF};
    vecs[5] = '{3, 1'b0, 1'b1, 1'b0, -32'sd65536,  1'b1, -32'sd65536};
    vecs[6] = '{2, 1'b0, 1'b1, 1'b1, 32'sd0,       1'b1, 32'sd0};

    // Reset state with all requesters asserting
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id",    64'(rsp_id), 64'd0);
    check("rst_ru_any",    64'(ru_any), 64'd0);
    check("rst_acc_T",     64'($unsigned(rsp_hit.T)), 64'($unsigned(INF)));
    req_valid = '0;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Single-batch traversals
    for (int i = 0; i < 7; i++) begin
      set_batch(vecs[i].id, vecs[i].any, 1'b1, vecs[i].hit, vecs[i].ahit, vecs[i].t, 14'(i));
      send(vecs[i].id, 1'b0, hs);
      check($sformatf("v%0d_ru_ray", i), 64'($unsigned(ru_ray.inv_dir.z)), 64'($unsigned(vecs[i].t)));
      check($sformatf("v%0d_ru_any", i), 64'(ru_any), 64'(vecs[i].any));
      wait_rsp(rc);
      check($sformatf("v%0d_latency", i), 64'(rc - hs), 64'd1);
      check($sformatf("v%0d_id", i), 64'(rsp_id), 64'(vecs[i].id));
      check($sformatf("v%0d_bhit", i), 64'(rsp_hit.bHit), 64'(vecs[i].exp_hit));
      check($sformatf("v%0d_T", i), 64'($unsigned(rsp_hit.T)), 64'($unsigned(vecs[i].exp_t)));
      ack_rsp();
    end

    // Reset while locked in WAIT with a hit accumulated
    set_batch(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'sd196608, 14'h11);
    send(1, 1'b0, hs);
    @(posedge clk); #1;
    check("wait_ready_owner", 64'(req_ready), 64'h2);
    check("wait_acc_hit", 64'(rsp_hit.bHit), 64'd1);
    resetn = 1'b0;
    #3;
    check("midrst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_acc_hit", 64'(rsp_hit.bHit), 64'd0);
    check("midrst_acc_T", 64'($unsigned(rsp_hit.T)), 64'($unsigned(INF)));
    set_batch(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'sd65536, 14'h12);
    set_batch(3, 1'b0, 1'b1, 1'b0, 1'b0, 32'sd65536, 14'h13);
    req_valid = 4'b1010;
    #1;
    check("midrst_rr_ptr", 64'(req_ready), 64'h2);
    send(1, 1'b0, hs);
    req_valid[3] = 1'b0;
    wait_rsp(rc);
    check("midrst_nohit_id", 64'(rsp_id), 64'd1);
    check("midrst_nohit_b", 64'(rsp_hit.bHit), 64'd0);
    check("midrst_nohit_T", 64'($unsigned(rsp_hit.T)), 64'($unsigned(INF)));
    ack_rsp();

    // Req1 three batches T=8,3,3: the first T=3 is kept; req0 locked out
    set_batch(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'sd524288, 14'h21);
    send(1, 1'b0, hs);
    set_batch(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'sd65536, 14'h20);
    req_valid[0] = 1'b1;
    mon_en = 1'b1;
    set_batch(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'sd196608, 14'h22);
    send(1, 1'b0, hs2);
    check("multi_batch_gap", 64'(hs2 - hs >= 2), 64'd1);
    set_batch(1, 1'b0, 1'b1, 1'b1, 1'b0, 32'sd196608, 14'h23);
    send(1, 1'b0, hs);
    wait_rsp(rc);
    mon_en = 1'b0;
    req_valid[0] = 1'b0;
    check("multi_id", 64'(rsp_id), 64'd1);
    check("multi_T", 64'($unsigned(rsp_hit.T)), 64'($unsigned(32'sd196608)));
    check("multi_tie_pid", 64'(rsp_hit.prim_id), 64'({2'b10, 14'h22}));
    check("multi_req0_locked", 64'(mon_bad), 64'd0);
    ack_rsp();

    // Req2 any-hit: hit on batch 2 ends the traversal early
    set_batch(2, 1'b1, 1'b0, 1'b0, 1'b0, 32'sd0, 14'h31);
    send(2, 1'b0, hs);
    set_batch(2, 1'b1, 1'b0, 1'b0, 1'b1, 32'sd0, 14'h32);
    send(2, 1'b0, hs);
    wait_rsp(rc);
    check("any_latency", 64'(rc - hs), 64'd1);
    check("any_id", 64'(rsp_id), 64'd2);
    check("any_bhit", 64'(rsp_hit.bHit), 64'd1);
    set_batch(2, 1'b1, 1'b0, 1'b0, 1'b0, 32'sd0, 14'h33);
    req_valid[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("any_no_3rd_%0d", k), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    req_valid[2] = 1'b0;
    ack_rsp();

    // All four requesting: round-robin 0,1,2,3,0 with a held response
    pulse_reset();
    for (int i = 0; i < 4; i++)
      set_batch(i, 1'b0, 1'b1, 1'b1, 1'b0, Fixed'((i + 1) * 65536), 14'(i));
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_ready = 4'(1 << (k % 4));
      #1;
      check($sformatf("rr_grant_%0d", k), 64'(req_ready), 64'(exp_ready));
      @(posedge clk); #1;
      wait_rsp(rc);
      exp_h = '{bHit: 1'b1, T: Fixed'((k % 4 + 1) * 65536), prim_id: {2'b10, 14'(k % 4)}};
      check($sformatf("rr_id_%0d", k), 64'(rsp_id), 64'(k % 4));
      check($sformatf("rr_hit_%0d", k), 64'(rsp_hit), 64'(exp_h));
      if (k == 0) begin
        for (int h = 0; h < 5; h++) begin
          @(posedge clk); #1;
          check($sformatf("hold_%0d", h), 64'({rsp_valid, rsp_id, rsp_hit}),
                64'({1'b1, 2'd0, exp_h}));
        end
      end
      ack_rsp();
    end
    req_valid = '0;

    // Closest traversal with no hits over two batches
`ifdef RAY_SCHED_PERF_EN
    pb0 = int'(perf_batches);
    pw0 = int'(perf_wait);
`else
    pb0 = 0;
    pw0 = 0;
`endif
    set_batch(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'sd262144, 14'h41);
    send(0, 1'b0, hs);
    repeat (3) @(posedge clk);
    #1;
    set_batch(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'sd131072, 14'h42);
    send(0, 1'b0, hs);
    wait_rsp(rc);
    check("nohit_id", 64'(rsp_id), 64'd0);
    check("nohit_b", 64'(rsp_hit.bHit), 64'd0);
    check("nohit_T", 64'($unsigned(rsp_hit.T)), 64'($unsigned(INF)));
`ifdef RAY_SCHED_PERF_EN
    check("perf_batches", 64'(int'(perf_batches) - pb0), 64'd2);
    check("perf_wait", 64'(int'(perf_wait) - pw0), 64'd2);
`endif
    ack_rsp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
